m_alu_arbiter: RTL

//  Shares one combinational m_alu (add/sub/xor, zero flag) between two requesters.

---
 rtl/m_alu_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/m_alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Operands are registered for one EXEC cycle; results land in per-requester response slots.

module m_alu_arbiter_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_out,
  input  logic             wr_zero,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  // A write only targets an empty slot, so the pop and the write never overlap.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    zero_d  = zero_q;
    if (valid_q && rsp_ready) valid_d = 1'b0;
    if (wr) begin
      valid_d = 1'b1;
      out_d   = wr_out;
      zero_d  = wr_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_out   = out_q;
  assign rsp_zero  = zero_q;
endmodule

module m_alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [CTL_W-1:0] req_ctl_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_out_0,
  output logic             rsp_zero_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [CTL_W-1:0] req_ctl_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_out_1,
  output logic             rsp_zero_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] op_count
);
  localparam int NUM_REQ = 2;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t                          state_q, state_d;
  logic                            last_q, last_d;
  logic                            owner_q, owner_d;
  logic [WIDTH-1:0]                alu_a_q, alu_a_d;
  logic [WIDTH-1:0]                alu_b_q, alu_b_d;
  logic [CTL_W-1:0]                alu_ctl_q, alu_ctl_d;
  logic [CNT_W-1:0]                op_count_q, op_count_d;

  logic [NUM_REQ-1:0]              req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, elig;
  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a, req_b, rsp_out;
  logic [NUM_REQ-1:0][CTL_W-1:0]   req_ctl;
  logic                            winner, grant;

  assign req_valid = {req_valid_1, req_valid_0};
  assign rsp_ready = {rsp_ready_1, rsp_ready_0};
  assign req_a     = {req_a_1, req_a_0};
  assign req_b     = {req_b_1, req_b_0};
  assign req_ctl   = {req_ctl_1, req_ctl_0};

  // A full slot that is popped this cycle frees up in time for the new result.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    winner = elig[1];
    if (&elig) winner = ~last_q;
    grant = (state_q == S_IDLE) && (|elig) && !reset;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctl_d  = alu_ctl_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: if (grant) begin
        alu_a_d   = req_a[winner];
        alu_b_d   = req_b[winner];
        alu_ctl_d = req_ctl[winner];
        owner_d   = winner;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        last_d     = owner_q;
        op_count_d = op_count_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctl_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctl_q  <= alu_ctl_d;
      op_count_q <= op_count_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    m_alu_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr        ((state_q == S_EXEC) && (owner_q == 1'(g))),
      .wr_out    (alu_out),
      .wr_zero   (alu_zero),
      .rsp_ready (rsp_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_out   (rsp_out[g]),
      .rsp_zero  (rsp_zero[g])
    );
  end

  assign req_ready_0 = req_ready[0];
  assign req_ready_1 = req_ready[1];
  assign rsp_valid_0 = rsp_valid[0];
  assign rsp_valid_1 = rsp_valid[1];
  assign rsp_out_0   = rsp_out[0];
  assign rsp_out_1   = rsp_out[1];
  assign rsp_zero_0  = rsp_zero[0];
  assign rsp_zero_1  = rsp_zero[1];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctl     = alu_ctl_q;
  assign op_count    = op_count_q;
endmodule
